// File: rtl/dpic_mem_arbiter.sv
// Arbitrates the single simulation memory port between IFU fetches and LSU loads/stores.
// One transaction in flight; LSU has priority unless the IFU has been passed over STARVE_LIMIT times.
module dpic_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [63:0] ifu_req_addr,
    output logic        ifu_resp_valid,
    input  logic        ifu_resp_ready,
    output logic [63:0] ifu_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_rdata,
    output logic        lsu_resp_err,
    output logic        mem_rd_en,
    output logic [63:0] mem_rd_addr,
    input  logic [63:0] mem_rd_data,
    output logic        mem_we_en,
    output logic [63:0] mem_we_addr,
    output logic [63:0] mem_we_data,
    output logic [7:0]  mem_we_mask
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_CAPT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [1:0]       r_state;
    logic             r_owner_lsu;
    logic             r_we;
    logic [CNT_W-1:0] r_starve;
    logic             r_mem_rd_en;
    logic [63:0]      r_mem_rd_addr;
    logic             r_mem_we_en;
    logic [63:0]      r_mem_we_addr;
    logic [63:0]      r_mem_we_data;
    logic [7:0]       r_mem_we_mask;
    logic             r_ifu_resp_valid;
    logic [63:0]      r_ifu_resp_data;
    logic             r_lsu_resp_valid;
    logic [63:0]      r_lsu_resp_rdata;
    logic             r_lsu_resp_err;

    logic w_idle;
    logic w_grant_ifu;
    logic w_grant_lsu;
    logic w_mask_ok;
    logic w_resp_hs;

    // Readys are gated by rst so every output reads 0 while reset is held.
    assign w_idle      = (r_state == S_IDLE) && !rst;
    assign w_grant_ifu = w_idle && ifu_req_valid && ((r_starve >= LIMIT) || !lsu_req_valid);
    assign w_grant_lsu = w_idle && lsu_req_valid && !w_grant_ifu;
    assign w_mask_ok   = (lsu_req_wmask == 8'h01) || (lsu_req_wmask == 8'h03) ||
                         (lsu_req_wmask == 8'h0F) || (lsu_req_wmask == 8'hFF);
    assign w_resp_hs   = (r_ifu_resp_valid && ifu_resp_ready) ||
                         (r_lsu_resp_valid && lsu_resp_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_owner_lsu      <= 1'b0;
            r_we             <= 1'b0;
            r_starve         <= '0;
            r_mem_rd_en      <= 1'b0;
            r_mem_rd_addr    <= '0;
            r_mem_we_en      <= 1'b0;
            r_mem_we_addr    <= '0;
            r_mem_we_data    <= '0;
            r_mem_we_mask    <= '0;
            r_ifu_resp_valid <= 1'b0;
            r_ifu_resp_data  <= '0;
            r_lsu_resp_valid <= 1'b0;
            r_lsu_resp_rdata <= '0;
            r_lsu_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ifu) begin
                        r_owner_lsu   <= 1'b0;
                        r_we          <= 1'b0;
                        r_starve      <= '0;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= ifu_req_addr;
                        r_state       <= S_ISSUE;
                    end else if (w_grant_lsu) begin
                        r_owner_lsu <= 1'b1;
                        r_we        <= lsu_req_we;
                        if (ifu_req_valid && (r_starve < LIMIT))
                            r_starve <= r_starve + 1'b1;
                        if (!lsu_req_we) begin
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= lsu_req_addr;
                        end else if (w_mask_ok) begin
                            r_mem_we_en   <= 1'b1;
                            r_mem_we_addr <= lsu_req_addr;
                            r_mem_we_data <= lsu_req_wdata;
                            r_mem_we_mask <= lsu_req_wmask;
                        end else begin
                            r_lsu_resp_err <= 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mem_rd_en <= 1'b0;
                    r_mem_we_en <= 1'b0;
                    // Only the LSU writes, so a write always answers on the LSU channel.
                    if (r_we) begin
                        r_lsu_resp_valid <= 1'b1;
                        r_lsu_resp_rdata <= '0;
                        r_state          <= S_RESP;
                    end else begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    if (r_owner_lsu) begin
                        r_lsu_resp_rdata <= mem_rd_data;
                        r_lsu_resp_valid <= 1'b1;
                    end else begin
                        r_ifu_resp_data  <= mem_rd_data;
                        r_ifu_resp_valid <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                default: begin
                    if (w_resp_hs) begin
                        r_ifu_resp_valid <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_lsu_resp_err   <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign ifu_req_ready  = w_grant_ifu;
    assign lsu_req_ready  = w_grant_lsu;
    assign ifu_resp_valid = r_ifu_resp_valid;
    assign ifu_resp_data  = r_ifu_resp_data;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign lsu_resp_rdata = r_lsu_resp_rdata;
    assign lsu_resp_err   = r_lsu_resp_err;
    assign mem_rd_en      = r_mem_rd_en;
    assign mem_rd_addr    = r_mem_rd_addr;
    assign mem_we_en      = r_mem_we_en;
    assign mem_we_addr    = r_mem_we_addr;
    assign mem_we_data    = r_mem_we_data;
    assign mem_we_mask    = r_mem_we_mask;
endmodule

// File: doc/dpic_mem_arbiter.md
Name: dpic_mem_arbiter

Overview:
- Shares the single DPI-C backed simulation memory port between instruction fetch (IFU, read-only) and load/store unit (LSU, read/write).
- Accepts one transaction at a time over valid/ready request channels and drives the memory's registered read/write controls.
- Captures read data and returns it on a per-requester valid/ready response channel.
- Arbitration is LSU-priority with an IFU anti-starvation override.

Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants while IFU waits, after which IFU wins the next arbitration.
- CNT_W, 3: width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_addr  in  64  IFU read address
- ifu_resp_valid  out  1  IFU read data valid
- ifu_resp_ready  in  1  IFU takes response
- ifu_resp_data  out  64  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_we  in  1  1 = write, 0 = read
- lsu_req_addr  in  64  LSU address
- lsu_req_wdata  in  64  write data
- lsu_req_wmask  in  8  byte mask
- lsu_resp_valid  out  1  LSU response valid (reads and writes)
- lsu_resp_ready  in  1  LSU takes response
- lsu_resp_rdata  out  64  LSU read data (0 for writes)
- lsu_resp_err  out  1  illegal write mask
- mem_rd_en  out  1  memory read enable
- mem_rd_addr  out  64  memory read address
- mem_rd_data  in  64  memory read data, valid the cycle after the edge that samples mem_rd_addr
- mem_we_en  out  1  memory write enable
- mem_we_addr  out  64  memory write address
- mem_we_data  out  64  memory write data
- mem_we_mask  out  8  memory write mask

Behaviour:
- FSM states: IDLE, ISSUE, CAPT, RESP. All mem_* outputs, response data, owner, err and starve count are registers.
- Reset (async, any state): state = IDLE; all outputs and counters = 0. An in-flight transaction is dropped with no response, and mem_we_en falls immediately.

IDLE:
- Arbitration picks the winner. IFU wins if ifu_req_valid and (starve count ≥ STARVE_LIMIT or !lsu_req_valid); otherwise LSU wins if lsu_req_valid.
- The winner's req_ready = 1 combinationally in IDLE only; the loser's ready = 0. Both readys are 0 in every other state.
- On handshake (edge E0): latch owner, we, addr, wdata, mask; go to ISSUE.
- Read at E0: mem_rd_en <= 1, mem_rd_addr <= addr.
- Write with legal mask (0x01, 0x03, 0x0F or 0xFF) at E0: mem_we_en <= 1, with addr/data/mask driven. mem_we_en is high for exactly one cycle.
- Write with any other mask at E0: mem_we_en stays 0; err flag <= 1.

ISSUE (edge E1):
- mem_rd_en <= 0 and mem_we_en <= 0.
- Read: go to CAPT.
- Write: go to RESP with owner resp_valid = 1 and resp_rdata = 0.

CAPT (edge E2):
- Response data register <= mem_rd_data; go to RESP with owner resp_valid = 1.
- mem_rd_data is ignored in every other state.

RESP:
- Owner resp_valid and its data/err are held stable until resp_ready = 1.
- The edge with resp_valid && resp_ready returns to IDLE; resp_valid = 0 and err clears.
- The non-owner resp_valid is always 0.

Latency:
- Read: resp_valid first high in the cycle after E2, minimum 3 cycles request-to-response.
- Write: resp_valid first high in the cycle after E1, minimum 2 cycles.
- Back-to-back: the next request is accepted in the first IDLE cycle after the response handshake.

Starvation counter:
- On an LSU grant with ifu_req_valid = 1: increment, saturating.
- On an IFU grant: clear.
- Otherwise: hold.
- lsu_resp_err only with LSU writes; IFU never sees an error.

Test Plan:
- IFU-only read, addr 0x8000_0000, memory returns 0x0000_0013_0000_0297 → mem_rd_en high exactly 1 cycle with that addr; ifu_resp_data = 0x0000_0013_0000_0297 3 cycles after handshake.
- LSU write addr 0x8000_1000, data 0x1122_3344_5566_7788, mask 0x0F → one-cycle mem_we_en with identical addr/data/mask; lsu_resp_valid 2 cycles later, err = 0, rdata = 0.
- LSU write with mask 0x06 → mem_we_en never asserted; lsu_resp_valid with err = 1.
- IFU and LSU both valid continuously, STARVE_LIMIT = 4 → grant order L,L,L,L,I,L,L,L,L,I…; no grant overlaps an open transaction.
- Response backpressure: ifu_resp_ready low for 5 cycles → resp_valid and data held constant, lsu_req_ready stays 0; grant to LSU on the cycle after ifu_resp_ready rises and handshake completes.
- Assert rst mid-write in ISSUE and mid-read in CAPT → all outputs 0 immediately (before the next clk edge); no response after reset release; the first new request completes normally.
